// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge
//   Receives CRC-8 framed commands from a UART byte receiver and turns them
//   into register-bus reads/writes. Reads return a CRC-8 framed response
//   through the UART byte transmitter.
//
//   Frame in : 0xCD, cmd, NB data bytes (LE), crc   (residue over all == 0)
//   Frame out: 0xDC, NB data bytes (LE), crc        (residue over all == 0)
//   cmd: 0x00 write, 0x01 set address, 0x02 clear err, 0x03 read.
//
// Ports
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   rx_data, rx_valid         received byte + one-cycle strobe
//   tx_data, tx_valid, tx_ready  response byte stream (valid/ready)
//   sys_wr, sys_rd            bus requests, held until sys_ack
//   sys_addr, sys_wdata       bus address / write data
//   sys_rdata, sys_ack        read data (sampled on read ack) / completion
//   err                       sticky error (bad CRC, bad cmd, stray byte,
//                             overrun, inter-byte timeout)
//   frame_ok                  one-cycle pulse per accepted frame
module uart_debug_bridge #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              sys_wr,
  output logic              sys_rd,
  output logic [ADDR_W-1:0] sys_addr,
  output logic [DATA_W-1:0] sys_wdata,
  input  logic [DATA_W-1:0] sys_rdata,
  input  logic              sys_ack,
  output logic              err,
  output logic              frame_ok
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE, CMD, DATA, CRC, BUSWR, BUSRD, TXHDR, TXDATA, TXCRC
  } state_t;

  state_t            state;
  logic [7:0]        crc;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data;
  logic [2:0]        bcnt;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] addr;

  logic [7:0]        crc_next;
  logic [DATA_W-1:0] data_shift;
  logic [ADDR_W-1:0] data_addr;
  logic              timed_out;

  // CRC-8, poly 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign crc_next = crc8_upd(crc, rx_data);
  assign sys_addr = addr;

  // Payload is little-endian: each new byte enters at the top, so after NB
  // bytes the first one received sits in the LSBs.
  generate
    if (DATA_W == 8) begin : g_shift8
      assign data_shift = rx_data;
    end else begin : g_shiftn
      assign data_shift = {rx_data, data[DATA_W-1:8]};
    end
  endgenerate

  // Zero-extends or truncates the payload to the address width.
  assign data_addr = ADDR_W'({{ADDR_W{1'b0}}, data});

  always_comb begin
    timed_out = 1'b0;
    if (TIMEOUT != 0 && state inside {CMD, DATA, CRC} && !rx_valid)
      timed_out = (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      crc       <= '0;
      cmd       <= '0;
      data      <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      addr      <= '0;
      sys_wr    <= 1'b0;
      sys_rd    <= 1'b0;
      sys_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      err       <= 1'b0;
      frame_ok  <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      tcnt     <= '0;
      if (state inside {CMD, DATA, CRC} && !rx_valid && !timed_out && TIMEOUT != 0)
        tcnt <= tcnt + TW'(1);

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == 8'hCD) begin
              crc   <= crc8_upd(8'h00, 8'hCD);
              state <= CMD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        CMD: begin
          if (rx_valid) begin
            cmd   <= rx_data;
            crc   <= crc_next;
            bcnt  <= '0;
            state <= DATA;
          end
        end

        DATA: begin
          if (rx_valid) begin
            data <= data_shift;
            crc  <= crc_next;
            if (bcnt == 3'(NB - 1)) state <= CRC;
            else                    bcnt  <= bcnt + 3'd1;
          end
        end

        CRC: begin
          if (rx_valid) begin
            crc   <= '0;
            state <= IDLE;
            if (crc_next != 8'h00) begin
              err <= 1'b1;
            end else begin
              case (cmd)
                8'h00: begin
                  frame_ok  <= 1'b1;
                  sys_wr    <= 1'b1;
                  sys_wdata <= data;
                  state     <= BUSWR;
                end
                8'h01: begin
                  frame_ok <= 1'b1;
                  addr     <= data_addr;
                end
                8'h02: begin
                  frame_ok <= 1'b1;
                  err      <= 1'b0;
                end
                8'h03: begin
                  frame_ok <= 1'b1;
                  sys_rd   <= 1'b1;
                  state    <= BUSRD;
                end
                default: err <= 1'b1;
              endcase
            end
          end
        end

        BUSWR: begin
          if (rx_valid) err <= 1'b1;
          if (sys_ack) begin
            sys_wr <= 1'b0;
            addr   <= addr + ADDR_W'(1);
            state  <= IDLE;
          end
        end

        BUSRD: begin
          if (rx_valid) err <= 1'b1;
          if (sys_ack) begin
            sys_rd   <= 1'b0;
            addr     <= addr + ADDR_W'(1);
            data     <= sys_rdata;
            tx_data  <= 8'hDC;
            tx_valid <= 1'b1;
            crc      <= crc8_upd(8'h00, 8'hDC);
            state    <= TXHDR;
          end
        end

        // The CRC register accumulates each byte as it is loaded into
        // tx_data, so by the last data byte it already holds the trailer.
        TXHDR: begin
          if (rx_valid) err <= 1'b1;
          if (tx_ready) begin
            tx_data <= data[7:0];
            crc     <= crc8_upd(crc, data[7:0]);
            data    <= data >> 8;
            bcnt    <= '0;
            state   <= TXDATA;
          end
        end

        TXDATA: begin
          if (rx_valid) err <= 1'b1;
          if (tx_ready) begin
            if (bcnt == 3'(NB - 1)) begin
              tx_data <= crc;
              state   <= TXCRC;
            end else begin
              tx_data <= data[7:0];
              crc     <= crc8_upd(crc, data[7:0]);
              data    <= data >> 8;
              bcnt    <= bcnt + 3'd1;
            end
          end
        end

        TXCRC: begin
          if (rx_valid) err <= 1'b1;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            crc      <= '0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (timed_out) begin
        err   <= 1'b1;
        crc   <= '0;
        data  <= '0;
        state <= IDLE;
      end
    end
  end

endmodule
